// File: rtl/stack_guard.sv
// stack_guard: depth tracker and move guard for a hardware stack (head + DEPTH-entry tail)
//   clk, resetq          : clock, asynchronous active-low reset
//   we_in, delta_in[1:0] : core head-write and move request (00 none, 01 push, 11 pop, 10 illegal)
//   clr                  : clears sticky flags and fault state, reloads hwm
//   we_out, delta_out    : head write and move to the stack, gated on errors when GUARD=1
//   depth, hwm           : occupied entries and high-water mark since last clr
//   ovf, unf, bad        : sticky overflow / underflow / illegal-move flags
//   fault, err           : FSM in FAULT, one-cycle pulse after every erroring cycle
module stack_guard #(
  parameter int DEPTH = 16,
  parameter bit GUARD = 1'b0
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       we_in,
  input  logic [1:0] delta_in,
  input  logic       clr,
  output logic       we_out,
  output logic [1:0] delta_out,
  output logic [5:0] depth,
  output logic [5:0] hwm,
  output logic       ovf,
  output logic       unf,
  output logic       bad,
  output logic       fault,
  output logic       err
);
  typedef enum logic {OK, FAULT} state_t;
  localparam logic [5:0] CAP = 6'(DEPTH + 1);
  state_t state;
  logic push, pop, push_ovf, pop_unf, illegal, event_any;
  logic [5:0] next_depth;
  always_comb begin
    push = delta_in == 2'b01;
    pop = delta_in == 2'b11;
    push_ovf = push && depth == CAP;
    pop_unf = pop && depth == 6'd0;
    illegal = delta_in == 2'b10;
    event_any = push_ovf || pop_unf || illegal;
    next_depth = (push && !push_ovf) ? depth + 6'd1 : (pop && !pop_unf) ? depth - 6'd1 : depth;
    we_out = (GUARD && event_any) ? 1'b0 : we_in;
    delta_out = (GUARD && event_any) ? 2'b00 : delta_in;
  end
  // An error in the same cycle as clr wins: only the new flag survives and fault stays set.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state <= OK;
      depth <= 6'd0;
      hwm <= 6'd0;
      ovf <= 1'b0;
      unf <= 1'b0;
      bad <= 1'b0;
      fault <= 1'b0;
      err <= 1'b0;
    end else begin
      depth <= next_depth;
      hwm <= (clr || next_depth > hwm) ? next_depth : hwm;
      ovf <= (ovf && !clr) || push_ovf;
      unf <= (unf && !clr) || pop_unf;
      bad <= (bad && !clr) || illegal;
      err <= event_any;
      if (event_any) begin
        state <= FAULT;
        fault <= 1'b1;
      end else if (clr) begin
        state <= OK;
        fault <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stack_guard.sv
// tb_stack_guard: randomized and directed checks of stack_guard against a behavioural stack model
module tb_stack_guard;
  localparam int DEPTH = 16;
  localparam int CAP = DEPTH + 1;
  logic clk = 1'b0;
  logic resetq = 1'b0;
  logic we = 1'b0;
  logic clr = 1'b0;
  logic [1:0] dl = 2'b00;
  logic we0, we1, ovf0, ovf1, unf0, unf1, bad0, bad1, fault0, fault1, err0, err1;
  logic [1:0] d0, d1;
  logic [5:0] depth0, depth1, hwm0, hwm1;
  int checks = 0;
  int errors = 0;
  int m_depth, m_hwm;
  bit m_ovf, m_unf, m_bad, m_fault, m_err;

  always #5 clk = ~clk;

  stack_guard #(.DEPTH(DEPTH), .GUARD(1'b0)) u0 (
    .clk(clk), .resetq(resetq), .we_in(we), .delta_in(dl), .clr(clr),
    .we_out(we0), .delta_out(d0), .depth(depth0), .hwm(hwm0),
    .ovf(ovf0), .unf(unf0), .bad(bad0), .fault(fault0), .err(err0));

  stack_guard #(.DEPTH(DEPTH), .GUARD(1'b1)) u1 (
    .clk(clk), .resetq(resetq), .we_in(we), .delta_in(dl), .clr(clr),
    .we_out(we1), .delta_out(d1), .depth(depth1), .hwm(hwm1),
    .ovf(ovf1), .unf(unf1), .bad(bad1), .fault(fault1), .err(err1));

  wire [16:0] act0 = {depth0, hwm0, ovf0, unf0, bad0, fault0, err0};
  wire [16:0] act1 = {depth1, hwm1, ovf1, unf1, bad1, fault1, err1};

  task automatic model_reset();
    m_depth = 0; m_hwm = 0;
    {m_ovf, m_unf, m_bad, m_fault, m_err} = '0;
  endtask

  function automatic bit model_error();
    return (dl == 2'b01 && m_depth == CAP) || (dl == 2'b11 && m_depth == 0) || dl == 2'b10;
  endfunction

  function automatic logic [16:0] model_regs();
    return {6'(m_depth), 6'(m_hwm), m_ovf, m_unf, m_bad, m_fault, m_err};
  endfunction

  task automatic drive(input bit w, input logic [1:0] d, input bit c);
    we = w; dl = d; clr = c;
  endtask

  // Advance one clock edge and move the model by the stack rules for the held inputs.
  task automatic tick();
    bit pov, pun, ill, e;
    @(posedge clk);
    pov = dl == 2'b01 && m_depth == CAP;
    pun = dl == 2'b11 && m_depth == 0;
    ill = dl == 2'b10;
    e = pov || pun || ill;
    if (dl == 2'b01 && !pov) m_depth++;
    if (dl == 2'b11 && !pun) m_depth--;
    m_hwm = clr ? m_depth : (m_depth > m_hwm ? m_depth : m_hwm);
    m_ovf = (m_ovf && !clr) || pov;
    m_unf = (m_unf && !clr) || pun;
    m_bad = (m_bad && !clr) || ill;
    m_fault = e ? 1'b1 : (clr ? 1'b0 : m_fault);
    m_err = e;
    #1;
  endtask

  task automatic run(input logic [1:0] d, input int n);
    repeat (n) begin drive(1'b0, d, 1'b0); tick(); end
  endtask

  task automatic apply_reset();
    resetq = 1'b0; drive(1'b0, 2'b00, 1'b0);
    model_reset();
    #2 resetq = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({act0, act1} !== 34'd0) begin
      errors++; $display("FAIL reset_state: got %h %h want 0", act0, act1);
    end
    drive(1'b1, 2'b11, 1'b0); #1;
    checks++;
    if ({we0, d0, we1, d1} !== {1'b1, 2'b11, 1'b0, 2'b00}) begin
      errors++; $display("FAIL reset_passthru: got %b want 1110000", {we0, d0, we1, d1});
    end
    model_reset();
    drive(1'b0, 2'b00, 1'b0);
    @(negedge clk) resetq = 1'b1;
  endtask

  task automatic test_fill();
    apply_reset();
    run(2'b01, CAP);
    checks++;
    if ({depth0, hwm0, ovf0, err0} !== {6'd17, 6'd17, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fill_full: got depth=%0d hwm=%0d ovf=%b want 17 17 0", depth0, hwm0, ovf0);
    end
    drive(1'b1, 2'b01, 1'b0); #1;
    checks++;
    if ({we0, d0, we1, d1} !== {1'b1, 2'b01, 1'b0, 2'b00}) begin
      errors++; $display("FAIL ovf_gate: got %b want 1010000", {we0, d0, we1, d1});
    end
    tick();
    checks++;
    if ({depth0, ovf0, err0, fault0, depth1, ovf1} !== {6'd17, 3'b111, 6'd17, 1'b1}) begin
      errors++; $display("FAIL ovf_event: got d=%0d ovf=%b err=%b fault=%b want 17 1 1 1", depth0, ovf0, err0, fault0);
    end
    run(2'b00, 1);
    checks++;
    if ({err0, ovf0, fault0} !== 3'b011) begin
      errors++; $display("FAIL ovf_err_once: got err=%b ovf=%b fault=%b want 0 1 1", err0, ovf0, fault0);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(1'b1, 2'b11, 1'b0); #1;
    checks++;
    if ({we0, d0, we1, d1} !== {1'b1, 2'b11, 1'b0, 2'b00}) begin
      errors++; $display("FAIL unf_gate: got %b want 1110000", {we0, d0, we1, d1});
    end
    tick();
    checks++;
    if ({unf1, depth1, unf0, depth0, fault1} !== {1'b1, 6'd0, 1'b1, 6'd0, 1'b1}) begin
      errors++; $display("FAIL unf_event: got unf=%b depth=%0d want 1 0", unf1, depth1);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] seq [4];
    int want [4];
    seq = '{2'b01, 2'b01, 2'b11, 2'b00};
    want = '{1, 2, 1, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], 1'b0); tick();
      checks++;
      if (depth0 !== 6'(want[i])) begin
        errors++; $display("FAIL seq_depth%0d: got %0d want %0d", i, depth0, want[i]);
      end
    end
    checks++;
    if ({hwm0, ovf0, unf0, bad0, fault0} !== {6'd2, 4'b0000}) begin
      errors++; $display("FAIL seq_flags: got hwm=%0d flags=%b want 2 0000", hwm0, {ovf0, unf0, bad0, fault0});
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    run(2'b01, 2);
    drive(1'b1, 2'b10, 1'b0); #1;
    checks++;
    if ({d0, d1, we1} !== {2'b10, 2'b00, 1'b0}) begin
      errors++; $display("FAIL bad_gate: got %b want 10000", {d0, d1, we1});
    end
    tick();
    checks++;
    if ({bad0, depth0, err0, fault0} !== {1'b1, 6'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL bad_event: got bad=%b depth=%0d err=%b want 1 2 1", bad0, depth0, err0);
    end
    drive(1'b0, 2'b00, 1'b1); tick();
    checks++;
    if ({bad0, fault0, err0, hwm0} !== {3'b000, 6'd2}) begin
      errors++; $display("FAIL bad_clr: got bad=%b fault=%b err=%b hwm=%0d want 0 0 0 2", bad0, fault0, err0, hwm0);
    end
  endtask

  task automatic test_clr_collision();
    apply_reset();
    run(2'b01, CAP + 1);
    run(2'b11, CAP);
    drive(1'b0, 2'b11, 1'b1); tick();
    checks++;
    if ({ovf0, unf0, fault0, err0, depth0} !== {4'b0111, 6'd0}) begin
      errors++; $display("FAIL clr_collide: got ovf=%b unf=%b fault=%b err=%b want 0 1 1 1", ovf0, unf0, fault0, err0);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    run(2'b01, CAP + 1);
    run(2'b11, 12);
    checks++;
    if ({depth0, ovf0} !== {6'd5, 1'b1}) begin
      errors++; $display("FAIL pre_reset: got depth=%0d ovf=%b want 5 1", depth0, ovf0);
    end
    resetq = 1'b0; #1;
    checks++;
    if ({depth0, ovf0, fault0, hwm0} !== 14'd0) begin
      errors++; $display("FAIL async_reset: got depth=%0d ovf=%b fault=%b want 0 0 0", depth0, ovf0, fault0);
    end
    model_reset();
    #1 resetq = 1'b1;
  endtask

  task automatic test_random();
    bit push_phase;
    int sel;
    for (int n = 0; n < 3000; n++) begin
      if (n % 48 == 0) push_phase = $urandom_range(0, 1);
      sel = $urandom_range(0, 19);
      drive($urandom_range(0, 1), sel < 11 ? (push_phase ? 2'b01 : 2'b11) : sel < 16 ? (push_phase ? 2'b11 : 2'b01) : sel < 19 ? 2'b00 : 2'b10, $urandom_range(0, 9) == 0);
      #1;
      checks++;
      if ({we0, d0, we1, d1} !== {we, dl, model_error() ? 3'b000 : {we, dl}}) begin
        errors++; $display("FAIL rnd_comb@%0d: got %b we=%b dl=%b", n, {we0, d0, we1, d1}, we, dl);
      end
      tick();
      checks++;
      if (act0 !== model_regs() || act1 !== model_regs()) begin
        errors++; $display("FAIL rnd_regs@%0d: got %h %h want %h", n, act0, act1, model_regs());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    @(posedge clk) #1;
    test_fill();
    test_underflow();
    test_sequence();
    test_illegal();
    test_clr_collision();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_guard.md
STACK_GUARD -- requirements
Module: stack_guard

Interface
REQ-001 Parameter DEPTH, default 16: tail depth of the downstream stack; capacity is DEPTH+1 entries (head plus tail); legal range 1..62.
REQ-002 Parameter GUARD, default 0: 0 means illegal moves are flagged and still forwarded; 1 means illegal moves are flagged and suppressed.
REQ-003 The block shall have one clock and an asynchronous, active-low reset; the ports are clk and resetq.
REQ-004 clk  input  1: single clock; all state updates on posedge.
REQ-005 resetq  input  1: asynchronous active-low reset.
REQ-006 we_in  input  1: head-write request from the core decode.
REQ-007 delta_in  input  2: move request from the core decode; 00 = none, 01 = push, 11 = pop, 10 = illegal.
REQ-008 clr  input  1: clears the sticky flags and the fault state.
REQ-009 we_out  output  1: head write enable to the stack (combinational).
REQ-010 delta_out  output  2: move control to the stack, same encoding as delta_in (combinational).
REQ-011 depth  output  6: current occupied entries, 0..DEPTH+1.
REQ-012 hwm  output  6: high-water mark of depth since the last clr.
REQ-013 ovf  output  1: sticky overflow flag.
REQ-014 unf  output  1: sticky underflow flag.
REQ-015 bad  output  1: sticky illegal-delta flag.
REQ-016 fault  output  1: FSM is in state FAULT.
REQ-017 err  output  1: one-cycle registered pulse, high in the cycle after any error event.

Function
REQ-018 Error events are evaluated combinationally each cycle:
- push_ovf = delta_in==01 and depth==DEPTH+1
- pop_unf = delta_in==11 and depth==0
- illegal = delta_in==10
REQ-019 When GUARD=0, we_out=we_in and delta_out=delta_in in every cycle.
REQ-020 When GUARD=1 and push_ovf, pop_unf or illegal is true, delta_out=00 and we_out=0; otherwise outputs pass through unchanged.
REQ-021 Depth update per cycle:
- +1 on a legal push (delta_in==01, depth<DEPTH+1)
- -1 on a legal pop (delta_in==11, depth>0)
- unchanged otherwise, including all error cases
- we_in never affects depth
REQ-022 On push_ovf with GUARD=0, depth shall saturate at DEPTH+1, since the bottom entry is lost in the stack.
REQ-023 On pop_unf, depth shall stay at 0.
REQ-024 hwm shall be set to the next depth value whenever that value exceeds hwm; the update is visible one cycle after the push.
REQ-025 ovf, unf and bad shall each set in the cycle after their respective event and hold until clr.
REQ-026 FSM has two states, OK and FAULT:
- OK -> FAULT on any error event.
- FAULT -> OK on clr, only when there is no error event in the same cycle.
REQ-027 Simultaneous clr and error event: the flags shall hold only the new event's flag (old flags cleared), fault shall stay 1, and err shall pulse.
REQ-028 clr shall set hwm to the current next-depth value and shall not change depth.
REQ-029 err shall be high for exactly one cycle per erroring cycle; consecutive erroring cycles give consecutive high cycles.

Reset
REQ-030 While resetq=0:
- depth=0, hwm=0
- ovf=unf=bad=0, err=0
- FSM in OK, fault=0
- assertion takes effect without a clock edge.
REQ-031 Reset asserted mid-operation shall discard depth and flags; the stack's contents are not tracked after reset, and depth restarts at 0.
REQ-032 we_out and delta_out remain combinational pass-through (gated per REQ-020) during reset.

Verification
REQ-033 DEPTH=16: 17 pushes from reset -> depth=17, hwm=17, ovf=0; an 18th push -> depth=17, ovf=1, err pulses once, fault=1.
REQ-034 Pop at depth 0 with GUARD=1 -> delta_out=00, we_out=0, unf=1, depth=0; with GUARD=0 -> delta_out=11.
REQ-035 push, push, pop, we_in-only (delta 00) -> depth sequence 1, 2, 1, 1; hwm=2; no flags set.
REQ-036 delta_in=10 for one cycle -> bad=1, depth unchanged, err high for exactly 1 cycle; clr next cycle -> bad=0, fault=0.
REQ-037 clr and underflow in the same cycle, with ovf previously set -> ovf=0, unf=1, fault=1.
REQ-038 resetq pulsed low between clock edges at depth=5 with ovf=1 -> depth=0, ovf=0, fault=0 immediately.
